// File: rtl/pipe_stage_buffer.sv
// Purpose : valid/ready pipeline stage register with optional 2-entry skid, flush and stall counter.
// Latency : 1 cycle from accept to out_valid/out_data when the stage is empty or draining.
// Backpr. : SKID=1 registered in_ready (drops only when both entries full); SKID=0 in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               kill all held entries and any same-cycle accepted input
//   in_valid/in_ready   upstream handshake, in_data is the payload
//   out_valid/out_ready downstream handshake, out_data is the head entry
//   occupancy           entries held (0..2)
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
module pipe_stage_buffer #(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q;
  logic             accept;
  logic             fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = 2'(state_q);
  assign stall_cnt = stall_q;

  // With the skid entry present, in_ready comes straight from a flop so the
  // backward ready path is cut; without it, ready ripples through from
  // out_ready in the same cycle.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && fire) begin
          // Head leaves as the new word arrives: stay single-entry.
          main_d = in_data;
        end else if (accept) begin
          // Only reachable with SKID=1; in SKID=0 accept implies fire.
          state_d = FULL;
          skid_d  = in_data;
        end else if (fire) begin
          // main_q is left as-is so out_data holds the last value.
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush wins over any handshake; a same-cycle fire has already been
    // consumed downstream, a same-cycle accept is simply thrown away.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end

    in_ready_d = (state_d != FULL);
  end

  // Saturating stall counter; flush deliberately leaves it alone so a debug
  // read after a branch storm still reflects the stalls that happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;

  localparam int W = 16;

  logic clk;
  logic rst;

  // Instance A: SKID=1, 16-bit counter
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic [15:0]  a_stall;

  // Instance B: SKID=0
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;
  logic [15:0]  b_stall;

  // Instance C: SKID=1, 4-bit counter
  logic         c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [W-1:0] c_in_data, c_out_data;
  logic [1:0]   c_occ;
  logic [3:0]   c_stall;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_buffer #(.WIDTH(W), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_buffer #(.WIDTH(W), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  pipe_stage_buffer #(.WIDTH(W), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .stall_cnt(c_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 1; a_in_data = 16'h55; a_out_ready = 0;
    b_flush = 0; b_in_valid = 1; b_in_data = 16'h55; b_out_ready = 0;
    c_flush = 0; c_in_valid = 1; c_in_data = 16'h55; c_out_ready = 0;

    // ---- reset held 2 cycles with in_valid=1
    tick();
    tick();
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_out_data",  64'(a_out_data),  64'd0);
    chk("rst_a_in_ready",  64'(a_in_ready),  64'd1);
    chk("rst_a_occ",       64'(a_occ),       64'd0);
    chk("rst_a_stall",     64'(a_stall),     64'd0);
    chk("rst_b_in_ready",  64'(b_in_ready),  64'd1);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_c_stall",     64'(c_stall),     64'd0);
    rst = 1'b0;
    a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;

    // ---- streaming 0x1..0x8 with out_ready=1
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1;
      a_in_data  = W'(i);
      tick();
      chk($sformatf("stream_valid_%0d", i), 64'(a_out_valid), 64'd1);
      chk($sformatf("stream_data_%0d", i),  64'(a_out_data),  64'(i));
      chk($sformatf("stream_occ_%0d", i),   64'(a_occ),       64'd1);
    end
    a_in_valid = 0;
    tick();
    chk("stream_drain_occ",  64'(a_occ),      64'd0);
    chk("stream_drain_data", 64'(a_out_data), 64'h8);
    chk("stream_stall",      64'(a_stall),    64'd0);

    // ---- backpressure 0xA, 0xB, 0xC
    a_out_ready = 0;
    a_in_valid  = 1;
    a_in_data   = 16'hA;
    tick();
    chk("bp1_data",     64'(a_out_data), 64'hA);
    chk("bp1_occ",      64'(a_occ),      64'd1);
    chk("bp1_in_ready", 64'(a_in_ready), 64'd1);
    chk("bp1_stall",    64'(a_stall),    64'd0);
    a_in_data = 16'hB;
    tick();
    chk("bp2_occ",      64'(a_occ),      64'd2);
    chk("bp2_in_ready", 64'(a_in_ready), 64'd0);
    chk("bp2_data",     64'(a_out_data), 64'hA);
    chk("bp2_stall",    64'(a_stall),    64'd1);
    a_in_data = 16'hC;
    tick();
    chk("bp3_occ",      64'(a_occ),      64'd2);
    chk("bp3_data",     64'(a_out_data), 64'hA);
    chk("bp3_stall",    64'(a_stall),    64'd2);
    a_out_ready = 1;
    tick();
    chk("bp4_data",     64'(a_out_data), 64'hB);
    chk("bp4_occ",      64'(a_occ),      64'd1);
    chk("bp4_in_ready", 64'(a_in_ready), 64'd1);
    chk("bp4_stall",    64'(a_stall),    64'd2);
    tick();
    chk("bp5_data",     64'(a_out_data), 64'hC);
    chk("bp5_occ",      64'(a_occ),      64'd1);
    a_in_valid = 0;
    tick();
    chk("bp6_occ",       64'(a_occ),       64'd0);
    chk("bp6_out_valid", 64'(a_out_valid), 64'd0);
    chk("bp6_hold_data", 64'(a_out_data),  64'hC);

    // ---- flush while FULL, input 0xD offered
    a_out_ready = 0;
    a_in_valid  = 1;
    a_in_data   = 16'h11;
    tick();
    a_in_data = 16'h12;
    tick();
    chk("fl_full_occ",   64'(a_occ),   64'd2);
    chk("fl_full_stall", 64'(a_stall), 64'd3);
    a_flush     = 1;
    a_in_data   = 16'hD;
    a_out_ready = 1;
    tick();
    chk("fl_out_valid", 64'(a_out_valid), 64'd0);
    chk("fl_occ",       64'(a_occ),       64'd0);
    chk("fl_data",      64'(a_out_data),  64'd0);
    chk("fl_in_ready",  64'(a_in_ready),  64'd1);
    chk("fl_stall",     64'(a_stall),     64'd3);
    a_flush    = 0;
    a_in_valid = 0;
    tick();
    chk("fl_after_valid", 64'(a_out_valid), 64'd0);
    chk("fl_after_data",  64'(a_out_data),  64'd0);

    // ---- flush while ONE, accepted input 0xE discarded
    a_out_ready = 0;
    a_in_valid  = 1;
    a_in_data   = 16'h21;
    tick();
    chk("fl1_data", 64'(a_out_data), 64'h21);
    a_flush   = 1;
    a_in_data = 16'hE;
    tick();
    chk("fl1_occ",   64'(a_occ),      64'd0);
    chk("fl1_data0", 64'(a_out_data), 64'd0);
    chk("fl1_stall", 64'(a_stall),    64'd4);
    a_flush    = 0;
    a_in_valid = 0;
    tick();
    chk("fl1_after_occ",   64'(a_occ),      64'd0);
    chk("fl1_after_data",  64'(a_out_data), 64'd0);
    chk("fl1_after_stall", 64'(a_stall),    64'd4);

    // ---- SKID=0 combinational ready
    b_out_ready = 0;
    b_in_valid  = 1;
    b_in_data   = 16'h31;
    #1;
    chk("s0_empty_ready", 64'(b_in_ready), 64'd1);
    tick();
    chk("s0_data1",  64'(b_out_data), 64'h31);
    chk("s0_occ1",   64'(b_occ),      64'd1);
    chk("s0_ready0", 64'(b_in_ready), 64'd0);
    b_in_data = 16'h32;
    #1;
    chk("s0_ready_held", 64'(b_in_ready), 64'd0);
    b_out_ready = 1;
    #1;
    chk("s0_ready_comb", 64'(b_in_ready), 64'd1);
    tick();
    chk("s0_data2", 64'(b_out_data), 64'h32);
    chk("s0_occ2",  64'(b_occ),      64'd1);
    b_in_valid = 0;
    tick();
    chk("s0_drain_occ",   64'(b_occ),       64'd0);
    chk("s0_drain_valid", 64'(b_out_valid), 64'd0);
    chk("s0_drain_ready", 64'(b_in_ready),  64'd1);
    chk("s0_stall",       64'(b_stall),     64'd0);

    // ---- saturation with 4-bit counter
    c_out_ready = 0;
    c_in_valid  = 1;
    c_in_data   = 16'h41;
    tick();
    c_in_valid = 0;
    chk("sat_start", 64'(c_stall), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_14", 64'(c_stall), 64'd14);
    end
    chk("sat_15",   64'(c_stall),    64'd15);
    chk("sat_data", 64'(c_out_data), 64'h41);
    c_flush = 1;
    tick();
    c_flush = 0;
    chk("sat_flush_stall", 64'(c_stall), 64'd15);
    chk("sat_flush_occ",   64'(c_occ),   64'd0);
    rst = 1;
    tick();
    rst = 0;
    chk("sat_rst_stall", 64'(c_stall), 64'd0);
    chk("a_rst_stall",   64'(a_stall), 64'd0);
    chk("a_rst_occ",     64'(a_occ),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline stage register replacing the fixed freeze/flush stage registers between pipeline stages (IF/ID first, then ID/EXE, EXE/MEM). It carries one opaque payload word (e.g. PC and instruction concatenated) with a valid/ready handshake, an optional 2-entry skid buffer that breaks the backward ready path, a synchronous flush that kills all in-flight entries, and a saturating stall-cycle counter for performance debug.

## Interface

- WIDTH, 64: payload width in bits (e.g. PC + instruction).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: stall counter width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all held entries and any same-cycle input (branch taken).
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage accepts a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage presents a payload.
- out_ready  input  1  downstream accepts this cycle (replaces ~freeze).
- out_data  output  WIDTH  payload at head of stage.
- occupancy  output  2  entries held: 0, 1 or 2 (2 only when SKID=1).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation

- accept = in_valid & in_ready; fire = out_valid & out_ready.
- Storage: main register (drives out_data) and, when SKID=1, skid register. out_valid = occupancy != 0.
- States (SKID=1): EMPTY, ONE, FULL.
  - EMPTY: in_ready=1. accept -> ONE, main <= in_data.
  - ONE: in_ready=1. accept & fire -> ONE, main <= in_data. accept & !fire -> FULL, skid <= in_data. !accept & fire -> EMPTY. Neither -> ONE.
  - FULL: in_ready=0. fire -> ONE, main <= skid. Else FULL.
- SKID=0: states EMPTY, ONE only; in_ready = !out_valid | out_ready; accept -> ONE with main <= in_data (also when fire same cycle); !accept & fire -> EMPTY.
- flush (priority over handshake, below rst): next state EMPTY, main and skid cleared to 0, same-cycle accepted input discarded, same-cycle fire still counts as a downstream transfer of the presented data.
- Order is strictly FIFO; no payload duplicated or dropped except by flush/rst.
- out_data after draining to EMPTY holds last value; after rst or flush it is 0.
- stall_cnt: +1 each cycle out_valid & !out_ready, saturates at 2^CNT_W-1, cleared only by rst (not by flush).

## Timing

- Reset values: out_valid=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1 (both modes, as state is EMPTY).
- Latency: payload accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when stage was EMPTY or main fires in N.
- Throughput: one payload per cycle sustained when out_ready=1.
- SKID=1: in_ready is a register output; no combinational path from out_ready or in_* to any output.
- SKID=0: combinational out_ready -> in_ready path only.
- flush in cycle N: cycle N+1 out_valid=0, occupancy=0, in_ready=1.
- rst asserted mid-operation overrides flush and handshake; takes effect at next edge.

## Test plan

- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming, SKID=1, out_ready=1: push 0x1..0x8 back-to-back -> out_data 0x1..0x8 in order on consecutive cycles, one cycle after each accept, occupancy stays 1.
- Backpressure, SKID=1: push 0xA, 0xB, 0xC with out_ready=0 -> 0xA, 0xB held, in_ready=0 after second accept, 0xC not accepted, occupancy=2, stall_cnt increments each cycle; release out_ready -> 0xA, 0xB, 0xC delivered in order.
- Flush in FULL with in_valid=1 data 0xD -> next cycle out_valid=0, occupancy=0, out_data=0, 0xD never appears; stall_cnt unchanged.
- SKID=0: out_ready=0 with entry held -> in_ready=0 same cycle; toggle out_ready=1 -> in_ready=1 combinationally, accept and fire same cycle, occupancy stays 1.
- Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays; flush leaves 15, rst clears to 0.
